// File: rtl/fft_rx_pkg.sv
// fft_rx_pkg
//   Shared types and helpers for the FFT stream receiver.
//   - rx_state_t     : receiver control states
//   - SRC_ERR_*      : source_error codes seen on the FFT source side
//   - addr_width()   : bin address width for an N-point frame
//   - beat_has_error(): true when a beat carries a nonzero error code
package fft_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      HOLD = 2'd2
   } rx_state_t;

   localparam logic [1:0] SRC_ERR_NONE    = 2'b00;
   localparam logic [1:0] SRC_ERR_MISSING = 2'b01;
   localparam logic [1:0] SRC_ERR_UNEXP   = 2'b10;
   localparam logic [1:0] SRC_ERR_OTHER   = 2'b11;

   // Smallest w with 2**w >= n.
   function automatic int addr_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   function automatic logic beat_has_error(input logic [1:0] code);
      return (code != SRC_ERR_NONE);
   endfunction

endpackage

// File: rtl/fft_bin_ram.sv
// fft_bin_ram
//   Simple dual-port RAM holding one FFT frame ({real, imag} per bin).
//   Ports:
//     clk      : clock
//     rd_clr_n : synchronous active-low clear of the read data register only
//     we/waddr/wdata : write port
//     re/raddr       : read request, data appears on rdata the next cycle
//     rdata          : registered read data (old data on read-during-write)
//   The storage array itself is never cleared so it maps onto block RAM.
module fft_bin_ram #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rd_clr_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; non-blocking read of mem yields old data on a collision.
   always_ff @(posedge clk) begin
      if (!rd_clr_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_stream_receiver.sv
// fft_stream_receiver
//   Avalon-ST sink for the FFT source side. Captures one N-point complex
//   frame into fft_bin_ram, checks sop/eop framing and source_error, then
//   holds the frame (frame_valid) for random-access reads until
//   frame_release re-arms the receiver.
//   Ports:
//     clk, reset_n            : clock, synchronous active-low reset
//     source_*                : FFT output stream (valid/sop/eop/error/real/imag)
//     source_ready            : registered ready, low while a frame is held
//     frame_valid             : complete frame present in RAM
//     frame_release           : consumer done with the held frame
//     rd_en/rd_addr           : read request; rd_real/rd_imag/rd_valid one cycle later
//     bin_count               : beats stored in the current frame
//     err_short/long/sop/stream : one-cycle framing error pulses
module fft_stream_receiver
   import fft_rx_pkg::*;
#(
   parameter int N        = 1024,
   parameter int fp_width = 32,
   parameter int ADDR_W   = addr_width(N)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                source_valid,
   input  logic                source_sop,
   input  logic                source_eop,
   input  logic [1:0]          source_error,
   input  logic [fp_width-1:0] source_real,
   input  logic [fp_width-1:0] source_imag,
   output logic                source_ready,
   output logic                frame_valid,
   input  logic                frame_release,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [fp_width-1:0] rd_real,
   output logic [fp_width-1:0] rd_imag,
   output logic                rd_valid,
   output logic [ADDR_W:0]     bin_count,
   output logic                err_short,
   output logic                err_long,
   output logic                err_sop,
   output logic                err_stream
);

   localparam int BIN_W = ADDR_W + 1;
   localparam logic [BIN_W-1:0] BIN_ZERO = '0;
   localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(32'd1);
   localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(N - 1);
   localparam logic [BIN_W-1:0] BIN_FULL = BIN_W'(N);

   rx_state_t        state_q, state_d;
   logic             source_ready_q, source_ready_d;
   logic             frame_valid_q, frame_valid_d;
   logic [BIN_W-1:0] bin_count_q, bin_count_d;
   logic             rd_valid_q, rd_valid_d;
   logic             err_short_q, err_short_d;
   logic             err_long_q, err_long_d;
   logic             err_sop_q, err_sop_d;
   logic             err_stream_q, err_stream_d;

   logic                  beat_acc_s;
   logic                  ram_we_s;
   logic [ADDR_W-1:0]     ram_waddr_s;
   logic [2*fp_width-1:0] ram_rdata_s;

   assign beat_acc_s = source_valid & source_ready_q;

   // Next-state, framing checks and RAM write control.
   always_comb begin
      state_d       = state_q;
      frame_valid_d = frame_valid_q;
      bin_count_d   = bin_count_q;
      err_short_d   = 1'b0;
      err_long_d    = 1'b0;
      err_sop_d     = 1'b0;
      err_stream_d  = 1'b0;
      ram_we_s      = 1'b0;
      ram_waddr_s   = bin_count_q[ADDR_W-1:0];
      rd_valid_d    = rd_en;

      case (state_q)
         IDLE: begin
            if (beat_acc_s) begin
               if (beat_has_error(source_error)) begin
                  err_stream_d = 1'b1;
               end else if (source_sop && source_eop) begin
                  // A one-beat frame can never be complete.
                  err_short_d = 1'b1;
               end else if (source_sop) begin
                  ram_we_s    = 1'b1;
                  ram_waddr_s = '0;
                  bin_count_d = BIN_ONE;
                  state_d     = RECV;
               end else begin
                  // Stray beat outside a frame: dropped.
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RECV: begin
            if (beat_acc_s) begin
               if (beat_has_error(source_error)) begin
                  err_stream_d = 1'b1;
                  bin_count_d  = BIN_ZERO;
                  state_d      = IDLE;
               end else if (source_sop) begin
                  // New sop wins over eop/length checks and restarts capture.
                  err_sop_d   = 1'b1;
                  ram_we_s    = 1'b1;
                  ram_waddr_s = '0;
                  bin_count_d = BIN_ONE;
               end else if (source_eop) begin
                  if (bin_count_q == BIN_LAST) begin
                     ram_we_s      = 1'b1;
                     bin_count_d   = BIN_FULL;
                     frame_valid_d = 1'b1;
                     state_d       = HOLD;
                  end else begin
                     err_short_d = 1'b1;
                     bin_count_d = BIN_ZERO;
                     state_d     = IDLE;
                  end
               end else if (bin_count_q == BIN_LAST) begin
                  err_long_d  = 1'b1;
                  bin_count_d = BIN_ZERO;
                  state_d     = IDLE;
               end else begin
                  ram_we_s    = 1'b1;
                  bin_count_d = bin_count_q + BIN_ONE;
               end
            end else begin
               state_d = RECV;
            end
         end
         HOLD: begin
            if (frame_release) begin
               frame_valid_d = 1'b0;
               bin_count_d   = BIN_ZERO;
               state_d       = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            frame_valid_d = 1'b0;
            bin_count_d   = BIN_ZERO;
            state_d       = IDLE;
         end
      endcase

      // Ready follows the state being entered so it is low from the first HOLD cycle.
      source_ready_d = (state_d != HOLD);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         source_ready_q <= 1'b0;
         frame_valid_q  <= 1'b0;
         bin_count_q    <= '0;
         rd_valid_q     <= 1'b0;
         err_short_q    <= 1'b0;
         err_long_q     <= 1'b0;
         err_sop_q      <= 1'b0;
         err_stream_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         source_ready_q <= source_ready_d;
         frame_valid_q  <= frame_valid_d;
         bin_count_q    <= bin_count_d;
         rd_valid_q     <= rd_valid_d;
         err_short_q    <= err_short_d;
         err_long_q     <= err_long_d;
         err_sop_q      <= err_sop_d;
         err_stream_q   <= err_stream_d;
      end
   end

   fft_bin_ram #(
      .DEPTH  (N),
      .DATA_W (2 * fp_width),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk      (clk),
      .rd_clr_n (reset_n),
      .we       (ram_we_s & reset_n),
      .waddr    (ram_waddr_s),
      .wdata    ({source_real, source_imag}),
      .re       (rd_en),
      .raddr    (rd_addr),
      .rdata    (ram_rdata_s)
   );

   assign source_ready = source_ready_q;
   assign frame_valid  = frame_valid_q;
   assign bin_count    = bin_count_q;
   assign rd_valid     = rd_valid_q;
   assign rd_real      = ram_rdata_s[2*fp_width-1:fp_width];
   assign rd_imag      = ram_rdata_s[fp_width-1:0];
   assign err_short    = err_short_q;
   assign err_long     = err_long_q;
   assign err_sop      = err_sop_q;
   assign err_stream   = err_stream_q;

endmodule
